// File: rtl/uart_pkg.sv
// Shared UART definitions: receive FSM states and framing constants.
package uart_pkg;

  localparam int UART_DATA_BITS            = 8;
  localparam int UART_DEFAULT_CLKS_PER_BIT = 868;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_IDLE
  } uart_rx_state_e;

endpackage

// File: rtl/uart_rx_fifo.sv
// Synchronous FIFO with wrap-bit pointers; shared by the UART RX and TX paths.
module uart_rx_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           pop_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_pop;
  logic             do_push;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign level = wr_ptr - rd_ptr;

  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  assign pop_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr[AW-1:0]] <= push_data;
        wr_ptr              <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART 8N1 receiver: synchronizes the line, frames bytes LSB first and queues
// them in a small FIFO for the register block.
module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_DEFAULT_CLKS_PER_BIT,
  parameter int FIFO_DEPTH   = 4,
  parameter int SYNC_STAGES  = 2
) (
  input  logic                          sys_clk_i,
  input  logic                          sys_rst_ni,
  input  logic                          uart_rx_i,
  output logic [UART_DATA_BITS-1:0]     rx_data_o,
  output logic                          rx_valid_o,
  input  logic                          rx_ready_i,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o,
  output logic                          busy_o,
  output logic                          frame_err_o,
  output logic                          overrun_o,
  input  logic                          overrun_clr_i
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

  logic [SYNC_STAGES-1:0]    sync_q;
  logic                      rx_s;
  uart_rx_state_e            state;
  logic [CW-1:0]             cnt;
  logic [2:0]                bit_idx;
  logic [UART_DATA_BITS-1:0] shreg;
  logic                      push_req;
  logic                      fifo_full;
  logic                      fifo_empty;

  always_ff @(posedge sys_clk_i or negedge sys_rst_ni) begin
    if (!sys_rst_ni) begin
      sync_q <= '1;
    end else begin
      sync_q[0] <= uart_rx_i;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign rx_s = sync_q[SYNC_STAGES-1];

  // Stop-bit sample with the line high: the byte is offered to the FIFO this cycle.
  assign push_req = (state == STOP) && (cnt == FULL_M1) && rx_s;

  always_ff @(posedge sys_clk_i or negedge sys_rst_ni) begin
    if (!sys_rst_ni) begin
      state       <= IDLE;
      cnt         <= '0;
      bit_idx     <= '0;
      shreg       <= '0;
      frame_err_o <= 1'b0;
    end else begin
      frame_err_o <= 1'b0;
      case (state)
        IDLE: begin
          if (!rx_s) begin
            state <= START;
            cnt   <= '0;
          end
        end
        START: begin
          if (cnt == HALF_M1) begin
            cnt     <= '0;
            bit_idx <= '0;
            state   <= rx_s ? IDLE : DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DATA: begin
          if (cnt == FULL_M1) begin
            cnt   <= '0;
            shreg <= {rx_s, shreg[UART_DATA_BITS-1:1]};
            if (bit_idx == 3'd7) state   <= STOP;
            else                 bit_idx <= bit_idx + 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        STOP: begin
          if (cnt == FULL_M1) begin
            cnt <= '0;
            if (rx_s) begin
              state <= IDLE;
            end else begin
              frame_err_o <= 1'b1;
              state       <= WAIT_IDLE;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        WAIT_IDLE: begin
          // Hold through a break so a stuck-low line does not produce a stream of frames.
          if (rx_s) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // A full FIFO cannot be popped unless it is non-empty, so a ready consumer always frees a slot.
  always_ff @(posedge sys_clk_i or negedge sys_rst_ni) begin
    if (!sys_rst_ni) begin
      overrun_o <= 1'b0;
    end else if (push_req && fifo_full && !rx_ready_i) begin
      overrun_o <= 1'b1;
    end else if (overrun_clr_i) begin
      overrun_o <= 1'b0;
    end
  end

  // Handshake: the head byte transfers on any rising edge where rx_valid_o and
  // rx_ready_i are both high; rx_data_o then shows the next entry.
  uart_rx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (UART_DATA_BITS)
  ) u_fifo (
    .clk       (sys_clk_i),
    .rst_n     (sys_rst_ni),
    .push      (push_req),
    .push_data (shreg),
    .pop       (rx_ready_i),
    .pop_data  (rx_data_o),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (fifo_level_o)
  );

  assign rx_valid_o = !fifo_empty;
  assign busy_o     = (state != IDLE);

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed bench for uart_rx_ctrl with an expected-byte queue as scoreboard.
`timescale 1ns/1ps
module tb_uart_rx_ctrl;

  localparam int CPB   = 16;
  localparam int DEPTH = 4;
  localparam int LW    = $clog2(DEPTH) + 1;
  // Start edge on the pin to first cycle rx_valid_o reads high.
  localparam int VALID_LAT = 3 + CPB / 2 + 9 * CPB;

  logic          clk;
  logic          rst_n;
  logic          uart_rx;
  logic [7:0]    rx_data;
  logic          rx_valid;
  logic          rx_ready;
  logic [LW-1:0] fifo_level;
  logic          busy;
  logic          frame_err;
  logic          overrun;
  logic          overrun_clr;

  logic [7:0] exp_q[$];
  int tests;
  int fails;
  int ferr_cnt;
  int lat;

  uart_rx_ctrl #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (DEPTH),
    .SYNC_STAGES  (2)
  ) dut (
    .sys_clk_i     (clk),
    .sys_rst_ni    (rst_n),
    .uart_rx_i     (uart_rx),
    .rx_data_o     (rx_data),
    .rx_valid_o    (rx_valid),
    .rx_ready_i    (rx_ready),
    .fifo_level_o  (fifo_level),
    .busy_o        (busy),
    .frame_err_o   (frame_err),
    .overrun_o     (overrun),
    .overrun_clr_i (overrun_clr)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (frame_err === 1'b1) ferr_cnt++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic drive_bit(input logic v);
    uart_rx = v;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop);
    @(negedge clk);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    drive_bit(stop);
  endtask

  task automatic send_good(input logic [7:0] d);
    if (exp_q.size() < DEPTH) exp_q.push_back(d);
    send_frame(d, 1'b1);
  endtask

  task automatic pop_check(input string tag);
    logic [7:0] e;
    @(negedge clk);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
    check("pop_valid", {31'd0, rx_valid}, 32'd1);
    check(tag, {24'd0, rx_data}, {24'd0, e});
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_data"},  {24'd0, rx_data}, 32'd0);
    check({tag, "_valid"}, {31'd0, rx_valid}, 32'd0);
    check({tag, "_level"}, {{(32-LW){1'b0}}, fifo_level}, 32'd0);
    check({tag, "_busy"},  {31'd0, busy}, 32'd0);
    check({tag, "_ferr"},  {31'd0, frame_err}, 32'd0);
    check({tag, "_ovr"},   {31'd0, overrun}, 32'd0);
  endtask

  initial begin
    tests = 0; fails = 0; ferr_cnt = 0;
    rst_n = 1'b0; uart_rx = 1'b1; rx_ready = 1'b0; overrun_clr = 1'b0;
    repeat (4) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    repeat (2 * CPB) @(negedge clk);

    // single byte with latency measurement
    exp_q.push_back(8'h54);
    lat = -1;
    fork
      send_frame(8'h54, 1'b1);
      begin
        @(negedge clk);
        for (int k = 1; k <= 400; k++) begin
          @(negedge clk);
          if (rx_valid === 1'b1) begin
            lat = k;
            break;
          end
        end
      end
    join
    check("valid_latency", lat, VALID_LAT);
    check("t_level", {{(32-LW){1'b0}}, fifo_level}, 32'd1);
    check("t_ferr_cnt", ferr_cnt, 0);
    pop_check("t_data");
    check("t_level_drained", {{(32-LW){1'b0}}, fifo_level}, 32'd0);

    // fill the FIFO, then overrun
    send_good(8'h54); send_good(8'h45); send_good(8'h53); send_good(8'h54);
    check("fill_level", {{(32-LW){1'b0}}, fifo_level}, exp_q.size());
    check("fill_ovr", {31'd0, overrun}, 32'd0);
    send_good(8'hA5);
    check("ovr_set", {31'd0, overrun}, 32'd1);
    check("ovr_level", {{(32-LW){1'b0}}, fifo_level}, exp_q.size());
    @(negedge clk); overrun_clr = 1'b1;
    @(negedge clk); overrun_clr = 1'b0;
    check("ovr_clr", {31'd0, overrun}, 32'd0);

    // push and pop together while full: level holds, no overrun
    fork
      send_frame(8'h5A, 1'b1);
      begin
        @(negedge clk);
        repeat (VALID_LAT - 1) @(negedge clk);
        check("simul_head", {24'd0, rx_data}, {24'd0, exp_q.pop_front()});
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
      end
    join
    exp_q.push_back(8'h5A);
    check("simul_ovr", {31'd0, overrun}, 32'd0);
    check("simul_level", {{(32-LW){1'b0}}, fifo_level}, exp_q.size());
    pop_check("drain0"); pop_check("drain1"); pop_check("drain2"); pop_check("drain3");
    check("drain_level", {{(32-LW){1'b0}}, fifo_level}, 32'd0);
    check("drain_valid", {31'd0, rx_valid}, 32'd0);

    // framing error followed by a held-low break
    send_frame(8'h3C, 1'b0);
    repeat (3 * CPB) @(negedge clk);
    check("ferr_pulse", ferr_cnt, 1);
    check("ferr_level", {{(32-LW){1'b0}}, fifo_level}, 32'd0);
    check("ferr_wait_busy", {31'd0, busy}, 32'd1);
    uart_rx = 1'b1;
    repeat (CPB) @(negedge clk);
    check("ferr_idle", {31'd0, busy}, 32'd0);
    send_good(8'h81);
    pop_check("after_ferr");
    check("ferr_total", ferr_cnt, 1);

    // short glitch on an idle line
    repeat (CPB) @(negedge clk);
    uart_rx = 1'b0;
    repeat (4) @(negedge clk);
    uart_rx = 1'b1;
    @(negedge clk);
    check("glitch_busy", {31'd0, busy}, 32'd1);
    repeat (3 * CPB) @(negedge clk);
    check("glitch_idle", {31'd0, busy}, 32'd0);
    check("glitch_level", {{(32-LW){1'b0}}, fifo_level}, 32'd0);
    check("glitch_ferr", ferr_cnt, 1);

    // reset during data bit 4 with two bytes queued
    send_good(8'h11); send_good(8'h22);
    check("pre_rst_level", {{(32-LW){1'b0}}, fifo_level}, 32'd2);
    fork
      send_frame(8'h77, 1'b1);
      begin
        @(negedge clk);
        repeat (5 * CPB + CPB / 2) @(negedge clk);
        check("pre_rst_busy", {31'd0, busy}, 32'd1);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("midrst");
        exp_q.delete();
      end
    join
    repeat (CPB) @(negedge clk);
    rst_n = 1'b1;
    repeat (CPB) @(negedge clk);
    check_reset_outputs("post_rst");
    send_good(8'h0F);
    pop_check("after_rst");
    check("final_level", {{(32-LW){1'b0}}, fifo_level}, 32'd0);
    check("final_ferr", ferr_cnt, 1);

    // final report
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
